// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
// master is the fetch stage itself; slave is the memory/decode/redirect side.
interface fetch_stage_if;
  logic [31:0] imem_pc_o;
  logic [31:0] imem_instr_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        misaligned_o;

  modport master (
    output imem_pc_o, valid_o, pc_o, instr_o, misaligned_o,
    input  imem_instr_i, redirect_valid_i, redirect_pc_i, ready_i
  );

  modport slave (
    input  imem_pc_o, valid_o, pc_o, instr_o, misaligned_o,
    output imem_instr_i, redirect_valid_i, redirect_pc_i, ready_i
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, buffers {pc, instr, misaligned} entries in a small
// circular buffer for decode, and restarts from a redirect target with a flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_stage_if.master bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]     pc_q, pc_d;
  logic            misal_q, misal_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;

  logic [31:0] ent_pc_q    [DEPTH];
  logic [31:0] ent_instr_q [DEPTH];
  logic        ent_mis_q   [DEPTH];

  logic full, pop, fetch;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full        = (count_q == CntW'(DEPTH));
  assign bus.valid_o = (count_q != '0);
  assign pop         = bus.valid_o && bus.ready_i;
  // A full buffer may still fetch when the head leaves in the same cycle.
  assign fetch       = !rst_i && !bus.redirect_valid_i && (!full || pop);

  assign bus.imem_pc_o    = pc_q;
  assign bus.pc_o         = bus.valid_o ? ent_pc_q[rd_q]    : '0;
  assign bus.instr_o      = bus.valid_o ? ent_instr_q[rd_q] : '0;
  assign bus.misaligned_o = bus.valid_o ? ent_mis_q[rd_q]   : 1'b0;

  always_comb begin
    pc_d    = pc_q;
    misal_d = misal_q;
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (bus.redirect_valid_i) begin
      pc_d    = {bus.redirect_pc_i[31:2], 2'b00};
      misal_d = |bus.redirect_pc_i[1:0];
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      if (pop) begin
        rd_d = ptr_inc(rd_q);
      end
      if (fetch) begin
        wr_d    = ptr_inc(wr_q);
        pc_d    = pc_q + 32'd4;
        misal_d = 1'b0;
      end
      count_d = count_q + CntW'(fetch) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      misal_q <= 1'b0;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]    <= '0;
        ent_instr_q[i] <= '0;
        ent_mis_q[i]   <= 1'b0;
      end
    end else begin
      pc_q    <= pc_d;
      misal_q <= misal_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (fetch) begin
        ent_pc_q[wr_q]    <= pc_q;
        ent_instr_q[wr_q] <= bus.imem_instr_i;
        ent_mis_q[wr_q]   <= misal_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a random run, all
// compared against a queue-based reference model of the fetch buffer.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   nchecks = 0;
  int   nerr    = 0;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h000F_50B7;
      32'h4:   return 32'h0000_2117;
      32'h8:   return 32'hFFF0_8193;
      32'hC:   return 32'h0000_4237;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign bus.imem_instr_i = imem(bus.imem_pc_o);

  // Reference model: queue of {pc, instr, misaligned}, next PC and pending flag.
  logic [64:0] mq[$];
  logic [31:0] mpc;
  logic        mmis;

  function automatic logic [97:0] model_out();
    logic [64:0] h;
    h = (mq.size() != 0) ? mq[0] : '0;
    return {mq.size() != 0, h[64:33], h[32:1], h[0], mpc};
  endfunction

  function automatic logic [97:0] dut_out();
    return {bus.valid_o, bus.pc_o, bus.instr_o, bus.misaligned_o, bus.imem_pc_o};
  endfunction

  // Advance one clock and apply the fetch rules to the model.
  task automatic cycle();
    logic r, rv, rdy, pop, fet;
    logic [31:0] rpc;
    r = rst; rv = bus.redirect_valid_i; rpc = bus.redirect_pc_i; rdy = bus.ready_i;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      mpc  = RESET_PC;
      mmis = 1'b0;
    end else begin
      pop = (mq.size() != 0) && rdy;
      fet = !rv && (mq.size() < 2 || pop);
      if (rv) begin
        mq.delete();
        mpc  = {rpc[31:2], 2'b00};
        mmis = |rpc[1:0];
      end else begin
        if (pop) void'(mq.pop_front());
        if (fet) begin
          mq.push_back({mpc, imem(mpc), mmis});
          mpc  = mpc + 32'd4;
          mmis = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ready_i = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i = '0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    nchecks++;
    if (dut_out() !== {1'b0, 32'h0, 32'h0, 1'b0, RESET_PC}) begin
      nerr++;
      $display("FAIL reset_state act=%h exp=%h", dut_out(), {1'b0, 64'h0, 1'b0, RESET_PC});
    end
    nchecks++;
    if (dut_out() !== model_out()) begin
      nerr++;
      $display("FAIL reset_model act=%h exp=%h", dut_out(), model_out());
    end
  endtask

  task automatic test_run();
    logic [31:0] exp_i [4];
    exp_i[0] = 32'h000F_50B7; exp_i[1] = 32'h0000_2117;
    exp_i[2] = 32'hFFF0_8193; exp_i[3] = 32'h0000_4237;
    do_reset();
    bus.ready_i = 1'b1;
    nchecks++;
    if (bus.valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL run_first_valid act=%b exp=0", bus.valid_o);
    end
    for (int k = 0; k < 4; k++) begin
      cycle();
      nchecks++;
      if ({bus.valid_o, bus.pc_o, bus.instr_o} !== {1'b1, 32'(4 * k), exp_i[k]}) begin
        nerr++;
        $display("FAIL run_seq%0d act=%b/%h/%h exp=1/%h/%h", k, bus.valid_o, bus.pc_o,
                 bus.instr_o, 32'(4 * k), exp_i[k]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 5; k++) cycle();
    nchecks++;
    if ({bus.imem_pc_o, bus.valid_o, bus.pc_o} !== {32'h8, 1'b1, 32'h0}) begin
      nerr++;
      $display("FAIL stall_hold act=%h/%b/%h exp=8/1/0", bus.imem_pc_o, bus.valid_o, bus.pc_o);
    end
    bus.ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nchecks++;
      if ({bus.valid_o, bus.pc_o} !== {1'b1, 32'(4 * k)}) begin
        nerr++;
        $display("FAIL stall_release%0d act=%b/%h exp=1/%h", k, bus.valid_o, bus.pc_o,
                 32'(4 * k));
      end
      cycle();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int k = 0; k < 3; k++) cycle();
    bus.ready_i = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'h100;
    nchecks++;
    if ({bus.valid_o, bus.pc_o} !== {1'b1, 32'h0}) begin
      nerr++;
      $display("FAIL redir_head act=%b/%h exp=1/0", bus.valid_o, bus.pc_o);
    end
    cycle();
    bus.redirect_valid_i = 1'b0;
    nchecks++;
    if ({bus.valid_o, bus.imem_pc_o} !== {1'b0, 32'h100}) begin
      nerr++;
      $display("FAIL redir_flush act=%b/%h exp=0/100", bus.valid_o, bus.imem_pc_o);
    end
    cycle();
    nchecks++;
    if ({bus.valid_o, bus.pc_o, bus.instr_o} !== {1'b1, 32'h100, imem(32'h100)}) begin
      nerr++;
      $display("FAIL redir_target act=%b/%h/%h exp=1/100/%h", bus.valid_o, bus.pc_o,
               bus.instr_o, imem(32'h100));
    end
  endtask

  task automatic test_misaligned();
    bus.ready_i = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'h203;
    cycle();
    bus.redirect_valid_i = 1'b0;
    nchecks++;
    if (bus.imem_pc_o !== 32'h200) begin
      nerr++;
      $display("FAIL misal_pc act=%h exp=200", bus.imem_pc_o);
    end
    cycle();
    nchecks++;
    if ({bus.valid_o, bus.pc_o, bus.misaligned_o} !== {1'b1, 32'h200, 1'b1}) begin
      nerr++;
      $display("FAIL misal_first act=%b/%h/%b exp=1/200/1", bus.valid_o, bus.pc_o,
               bus.misaligned_o);
    end
    cycle();
    nchecks++;
    if ({bus.valid_o, bus.pc_o, bus.misaligned_o} !== {1'b1, 32'h204, 1'b0}) begin
      nerr++;
      $display("FAIL misal_next act=%b/%h/%b exp=1/204/0", bus.valid_o, bus.pc_o,
               bus.misaligned_o);
    end
  endtask

  task automatic test_wrap();
    bus.ready_i = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    cycle();
    bus.redirect_valid_i = 1'b0;
    cycle();
    nchecks++;
    if ({bus.valid_o, bus.pc_o} !== {1'b1, 32'hFFFF_FFFC}) begin
      nerr++;
      $display("FAIL wrap_last act=%b/%h exp=1/fffffffc", bus.valid_o, bus.pc_o);
    end
    cycle();
    nchecks++;
    if ({bus.valid_o, bus.pc_o, bus.instr_o} !== {1'b1, 32'h0, 32'h000F_50B7}) begin
      nerr++;
      $display("FAIL wrap_zero act=%b/%h/%h exp=1/0/000f50b7", bus.valid_o, bus.pc_o,
               bus.instr_o);
    end
  endtask

  task automatic test_reset_mid();
    bus.ready_i = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'h400;
    cycle();
    bus.redirect_valid_i = 1'b0;
    bus.ready_i = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    nchecks++;
    if ({bus.valid_o, bus.imem_pc_o, bus.pc_o} !== {1'b0, RESET_PC, 32'h0}) begin
      nerr++;
      $display("FAIL midrst_flush act=%b/%h/%h exp=0/%h/0", bus.valid_o, bus.imem_pc_o,
               bus.pc_o, RESET_PC);
    end
    bus.ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      nchecks++;
      if ({bus.valid_o, bus.pc_o} !== {1'b1, RESET_PC + 32'(4 * k)}) begin
        nerr++;
        $display("FAIL midrst_seq%0d act=%b/%h exp=1/%h", k, bus.valid_o, bus.pc_o,
                 RESET_PC + 32'(4 * k));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    cycle();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.ready_i = ($urandom_range(0, 2) != 0);
      bus.redirect_valid_i = ($urandom_range(0, 9) == 0);
      bus.redirect_pc_i = $urandom();
      cycle();
      nchecks++;
      if (dut_out() !== model_out()) begin
        nerr++;
        $display("FAIL random%0d act=%h exp=%h", k, dut_out(), model_out());
      end
    end
    rst = 1'b0;
    bus.redirect_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.ready_i = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i = '0;
    mpc = RESET_PC;
    mmis = 1'b0;
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the tartaruga core. It owns the program counter and presents the PC to the instruction memory, which returns the instruction word combinationally in the same cycle. It captures the {PC, instruction} pair into a 2-entry output buffer and hands it to decode over a valid/ready handshake. It also accepts redirects (branch/jump targets) from later stages, which flush the buffer.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- DEPTH, 2: output buffer entries; only 2 is required to be supported.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- imem_pc_o  out  32  PC presented to instruction memory; always the current PC register.
- imem_instr_i  in  32  instruction word for imem_pc_o, valid in the same cycle.
- redirect_valid_i  in  1  redirect request, single-cycle pulse or held.
- redirect_pc_i  in  32  redirect target.
- valid_o  out  1  buffer head holds a fetched instruction.
- ready_i  in  1  decode accepts the head this cycle.
- pc_o  out  32  PC of the head entry.
- instr_o  out  32  instruction of the head entry.
- misaligned_o  out  1  head entry came from a redirect target with bits [1:0] != 0.

## Operation
- State: pc_q (32), count_q (0..2), 2-entry circular buffer (rd/wr pointers, each entry {pc, instr, misaligned}), and misal_q, a sticky flag for the next push.
- pop = valid_o && ready_i. Head advances; count decrements.
- fetch = !rst_i && !redirect_valid_i && (count_q < 2 || pop). On fetch:
  - push {pc_q, imem_instr_i, misal_q};
  - pc_q <= pc_q + 32'd4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0);
  - misal_q <= 0.
- Full buffer with simultaneous pop: pop and push both happen in the same cycle; count stays 2.
- Redirect has priority over fetch:
  - buffer flushed, count_q <= 0, no push;
  - pc_q <= {redirect_pc_i[31:2], 2'b00};
  - misal_q <= |redirect_pc_i[1:0].
- Redirect coinciding with pop: the head transfer still counts as accepted. Killing a wrong-path instruction is decode's responsibility.
- Outputs: valid_o = (count_q != 0). pc_o, instr_o and misaligned_o come from the head entry when valid_o = 1, and are 0 when valid_o = 0.
- Output stability: while valid_o && !ready_i and no redirect, pc_o, instr_o and misaligned_o hold stable.
- No combinational path from ready_i to imem_pc_o; imem_pc_o depends only on pc_q.

## Timing
- Reset (rst_i high at an edge): pc_q = RESET_PC, count_q = 0, pointers = 0, misal_q = 0, entries cleared.
  - Output values after reset: imem_pc_o = RESET_PC, valid_o = 0, pc_o = 0, instr_o = 0, misaligned_o = 0.
- Reset asserted mid-stream: all in-flight entries are discarded at that edge.
- Latency: the instruction at PC X is fetched in cycle N and appears on valid_o/pc_o/instr_o in cycle N+1.
- Throughput: one instruction per cycle while ready_i is held high.
- Stall: with ready_i low, two fetches complete, then the PC holds. On ready_i rising, the head pops and a new fetch occurs in that same cycle.
- Redirect: target presented on imem_pc_o in cycle N+1; target instruction valid on outputs in cycle N+2; valid_o = 0 in cycle N+1.

## Test plan
- Reset then run, ready_i = 1, imem model returns 0x000F50B7 / 0x00002117 / 0xFFF08193 / 0x00004237 at 0x0 / 0x4 / 0x8 / 0xC -> outputs match one per cycle starting the cycle after reset release, pc_o = 0x0, 0x4, 0x8, 0xC; valid_o = 0 in the first cycle.
- ready_i = 0 for 5 cycles after reset -> imem_pc_o stops at 0x8, valid_o = 1 holding pc_o = 0x0; ready_i = 1 -> pc_o 0x0, 0x4, 0x8 on consecutive cycles, no gaps, no duplicates.
- Redirect to 0x100 while buffer full and ready_i = 1 -> head accepted that cycle; next cycle valid_o = 0 and imem_pc_o = 0x100; following cycle pc_o = 0x100.
- Redirect to 0x203 -> imem_pc_o = 0x200; entry 0x200 has misaligned_o = 1; entry 0x204 has misaligned_o = 0.
- Redirect to 0xFFFF_FFFC, ready_i = 1 -> pc_o sequence 0xFFFF_FFFC then 0x0000_0000.
- rst_i asserted for one cycle with two entries buffered and ready_i low -> next cycle valid_o = 0 and imem_pc_o = RESET_PC; stale entries never appear on the outputs.
